// File: rtl/frame_receiver_pkg.sv
// frame_receiver_pkg: shared sensor geometry, receiver state enum and pixel index helpers.
package frame_receiver_pkg;

    localparam int PIXEL_ARRAY_WIDTH  = 24;
    localparam int PIXEL_ARRAY_HEIGHT = 3;
    localparam int OUTPUT_BUS_WIDTH   = 8;
    localparam int PIXEL_BITS         = 8;
    localparam int BEATS_PER_ROW      = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int BEATS_PER_FRAME    = BEATS_PER_ROW * PIXEL_ARRAY_HEIGHT;
    localparam int PIXELS_PER_FRAME   = PIXEL_ARRAY_WIDTH * PIXEL_ARRAY_HEIGHT;
    localparam int BEAT_BITS          = OUTPUT_BUS_WIDTH * PIXEL_BITS;

    localparam int WORD_W = $clog2(BEATS_PER_FRAME);
    localparam int IDX_W  = $clog2(PIXELS_PER_FRAME);
    localparam int ROW_W  = $clog2(PIXEL_ARRAY_HEIGHT);
    localparam int COL_W  = $clog2(PIXEL_ARRAY_WIDTH);
    localparam int LANE_W = $clog2(OUTPUT_BUS_WIDTH);

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BEATS_PER_FRAME - 1);
    localparam logic [IDX_W-1:0]  LAST_PIX  = IDX_W'(PIXELS_PER_FRAME - 1);

    typedef enum logic {CAPTURE, READOUT} rx_state_t;

    function automatic logic [ROW_W-1:0] idx_row(input logic [IDX_W-1:0] idx);
        return ROW_W'(idx / IDX_W'(PIXEL_ARRAY_WIDTH));
    endfunction

    function automatic logic [COL_W-1:0] idx_col(input logic [IDX_W-1:0] idx);
        return COL_W'(idx % IDX_W'(PIXEL_ARRAY_WIDTH));
    endfunction

    // Beat word holding a given pixel: one row spans BEATS_PER_ROW consecutive words
    function automatic logic [WORD_W-1:0] word_of(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
        return WORD_W'(row) * WORD_W'(BEATS_PER_ROW) + WORD_W'(col >> LANE_W);
    endfunction

endpackage

// File: rtl/frame_store.sv
// frame_store: one-frame beat memory with a write port and a combinational pixel-select read port.
module frame_store
    import frame_receiver_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [WORD_W-1:0]     waddr,
    input  logic [BEAT_BITS-1:0]  wdata,
    input  logic [ROW_W-1:0]      row,
    input  logic [COL_W-1:0]      col,
    output logic [PIXEL_BITS-1:0] pixel
);

    logic [BEAT_BITS-1:0] mem [BEATS_PER_FRAME];
    logic [BEAT_BITS-1:0] word;

    always_ff @(posedge clk)
        if (we)
            mem[waddr] <= wdata;

    assign word  = mem[word_of(row, col)];
    assign pixel = word[col[LANE_W-1:0]*PIXEL_BITS +: PIXEL_BITS];

endmodule

// File: rtl/frame_receiver.sv
// frame_receiver: captures a 9-beat sensor frame, then streams its 72 pixels out row-major
// with valid/ready handshaking and sticky short-frame / overrun error flags.
module frame_receiver
    import frame_receiver_pkg::*;
#(
    parameter bit CHECK_OVERRUN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  beat_valid,
    input  logic [BEAT_BITS-1:0]  data_in,
    input  logic                  frame_finished,
    input  logic                  pix_ready,
    input  logic                  clear_err,
    output logic                  pix_valid,
    output logic [PIXEL_BITS-1:0] pix_data,
    output logic [ROW_W-1:0]      pix_row,
    output logic [COL_W-1:0]      pix_col,
    output logic                  frame_done,
    output logic                  short_frame,
    output logic                  overrun
);

    rx_state_t             state, state_nxt;
    logic [WORD_W-1:0]     beat_cnt, beat_cnt_nxt;
    logic [IDX_W-1:0]      pix_idx, pix_idx_nxt;
    logic                  short_nxt, overrun_nxt, done_nxt;
    logic                  store, last_beat, accept, last_pix;
    logic [PIXEL_BITS-1:0] pixel;

    assign store     = (state == CAPTURE) && beat_valid;
    assign last_beat = store && (beat_cnt == LAST_WORD);
    assign accept    = pix_valid && pix_ready;
    assign last_pix  = accept && (pix_idx == LAST_PIX);

    assign pix_valid = (state == READOUT);
    assign pix_row   = idx_row(pix_idx);
    assign pix_col   = idx_col(pix_idx);
    assign pix_data  = pix_valid ? pixel : '0;

    frame_store u_store (
        .clk   (clk),
        .we    (store),
        .waddr (beat_cnt),
        .wdata (data_in),
        .row   (pix_row),
        .col   (pix_col),
        .pixel (pixel)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= CAPTURE;
            beat_cnt    <= '0;
            pix_idx     <= '0;
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            beat_cnt    <= beat_cnt_nxt;
            pix_idx     <= pix_idx_nxt;
            frame_done  <= done_nxt;
            short_frame <= short_nxt;
            overrun     <= overrun_nxt;
        end

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        pix_idx_nxt  = pix_idx;
        short_nxt    = short_frame & ~clear_err;
        overrun_nxt  = overrun & ~clear_err;
        done_nxt     = last_pix;
        if (state == CAPTURE) begin
            // A completing beat outranks a coincident end-of-frame pulse
            if (last_beat) begin
                state_nxt    = READOUT;
                beat_cnt_nxt = '0;
            end else if (frame_finished) begin
                short_nxt    = 1'b1;
                beat_cnt_nxt = '0;
            end else if (store) begin
                beat_cnt_nxt = beat_cnt + 1'b1;
            end
        end else begin
            overrun_nxt = overrun_nxt | (beat_valid & CHECK_OVERRUN);
            pix_idx_nxt = last_pix ? '0 : pix_idx + IDX_W'(accept);
            state_nxt   = last_pix ? CAPTURE : READOUT;
        end
    end

endmodule

// File: tb/tb_frame_receiver.sv
// tb_frame_receiver: scoreboard bench; expected pixels are queued as beats are driven
// and popped as the receiver hands pixels over.
module tb_frame_receiver;
    import frame_receiver_pkg::*;

    logic        clk = 1'b0, reset = 1'b1, beat_valid = 1'b0, frame_finished = 1'b0;
    logic        pix_ready = 1'b1, clear_err = 1'b0;
    logic [63:0] data_in = '0;
    logic        pix_valid, frame_done, short_frame, overrun;
    logic [7:0]  pix_data;
    logic [1:0]  pix_row;
    logic [4:0]  pix_col;

    logic [14:0] exp_q [$];
    logic [14:0] held, exp_px;
    bit          held_v = 1'b0, toggle = 1'b0;
    int          checks = 0, errors = 0, dones = 0, nframes = 0;

    frame_receiver #(.CHECK_OVERRUN(1'b1)) dut (
        .clk            (clk),
        .reset          (reset),
        .beat_valid     (beat_valid),
        .data_in        (data_in),
        .frame_finished (frame_finished),
        .pix_ready      (pix_ready),
        .clear_err      (clear_err),
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .pix_row        (pix_row),
        .pix_col        (pix_col),
        .frame_done     (frame_done),
        .short_frame    (short_frame),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [63:0] d, input bit ff);
        beat_valid     = 1'b1;
        data_in        = d;
        frame_finished = ff;
        @(posedge clk); #1;
        beat_valid     = 1'b0;
        frame_finished = 1'b0;
    endtask

    // n beats; patt selects value w*8+j, otherwise random bytes; push queues expected pixels
    task automatic frame(input int n, input bit patt, input bit push, input bit ff_last);
        logic [63:0] d;
        for (int w = 0; w < n; w++) begin
            for (int j = 0; j < 8; j++) begin
                d[j*8 +: 8] = patt ? 8'(w * 8 + j) : 8'($urandom);
                if (push)
                    exp_q.push_back({d[j*8 +: 8], 2'(w / 3), 5'((w % 3) * 8 + j)});
            end
            beat(d, ff_last && (w == n - 1));
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (frame_done)
                break;
        end
        check("done_seen", 64'(frame_done), 64'd1);
        check("q_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
    endtask

    initial forever begin
        @(posedge clk); #1;
        pix_ready = toggle ? ~pix_ready : 1'b1;
    end

    // Monitor: pops the scoreboard on each transfer and checks stall stability
    initial forever begin
        @(negedge clk);
        if (reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v)
                check("stall_hold", 64'({pix_valid, pix_data, pix_row, pix_col}), 64'({1'b1, held}));
            if (!pix_valid)
                check("idle_data", 64'(pix_data), 64'd0);
            if (frame_done)
                dones++;
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_pix", 64'(exp_q.size()), 64'd1);
                end else begin
                    exp_px = exp_q.pop_front();
                    check("pixel", 64'({pix_data, pix_row, pix_col}), 64'(exp_px));
                end
            end
            held_v = pix_valid && !pix_ready;
            held   = {pix_data, pix_row, pix_col};
        end
    end

    initial begin
        bit found;
        #12;
        check("reset_outs", 64'({pix_valid, frame_done, short_frame, overrun, pix_data, pix_row, pix_col}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Ordered pattern frame, consumer always ready
        frame(9, 1'b1, 1'b1, 1'b0);
        check("valid_first", 64'(pix_valid), 64'd1);
        wait_done();
        nframes++;

        // Back-to-back frame starting in the done cycle, consumer stalling every other cycle
        toggle = 1'b1;
        frame(9, 1'b0, 1'b1, 1'b0);
        check("valid_first2", 64'(pix_valid), 64'd1);
        wait_done();
        nframes++;
        toggle = 1'b0;

        // Short frame: flag set, nothing read out, next full frame correct
        frame(5, 1'b0, 1'b0, 1'b0);
        frame_finished = 1'b1;
        @(posedge clk); #1;
        frame_finished = 1'b0;
        check("short_set", 64'(short_frame), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("short_noval", 64'(pix_valid), 64'd0);
        frame(9, 1'b0, 1'b1, 1'b0);
        wait_done();
        nframes++;
        check("short_sticky", 64'(short_frame), 64'd1);
        pulse_clear();
        check("short_clr", 64'(short_frame), 64'd0);

        // Overrun during readout, clear racing a new overrun, then a plain clear
        frame(9, 1'b0, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("ovr_pre", 64'(overrun), 64'd0);
        beat(64'hdead_beef_cafe_f00d, 1'b0);
        check("ovr_set", 64'(overrun), 64'd1);
        beat_valid = 1'b1;
        clear_err  = 1'b1;
        @(posedge clk); #1;
        beat_valid = 1'b0;
        clear_err  = 1'b0;
        check("ovr_set_wins", 64'(overrun), 64'd1);
        pulse_clear();
        check("ovr_clr", 64'(overrun), 64'd0);
        wait_done();
        nframes++;

        // Last beat coincides with end-of-frame pulse
        frame(9, 1'b0, 1'b1, 1'b1);
        check("ff_last_val", 64'(pix_valid), 64'd1);
        check("ff_last_short", 64'(short_frame), 64'd0);
        wait_done();
        nframes++;

        // Reset mid-readout at pixel 30, then a fresh frame
        frame(9, 1'b0, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #2;
            found = pix_valid && (pix_row == 2'd1) && (pix_col == 5'd6);
        end
        check("reach_px30", 64'(found), 64'd1);
        reset = 1'b1;
        #1;
        check("reset_mid", 64'({pix_valid, frame_done, short_frame, overrun, pix_data, pix_row, pix_col}), 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        frame(9, 1'b1, 1'b1, 1'b0);
        check("post_reset_val", 64'(pix_valid), 64'd1);
        check("post_reset_idx", 64'({pix_row, pix_col}), 64'd0);
        wait_done();
        nframes++;

        repeat (5) @(negedge clk);
        check("done_total", 64'(dones), 64'(nframes));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
